// File: rtl/elevator_scheduler.sv
// SCAN (collective) call scheduler for an 8-landing car: latches floor calls,
// tracks car position with a travel timer, and sequences motor and door commands.
module elevator_scheduler #(
    parameter int FLOORS     = 8,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FLOORS-1:0]         req,
    input  logic                      inopen,
    input  logic                      inclose,
    output logic [FLOORS-1:0]         pending,
    output logic [$clog2(FLOORS)-1:0] pfloor,
    output logic [$clog2(FLOORS)-1:0] nfloor,
    output logic                      up,
    output logic                      down,
    output logic                      open,
    output logic                      close
);

    localparam int FW = $clog2(FLOORS);
    localparam int TW = $clog2(TRAVEL_CYC);
    localparam int DW = $clog2(DOOR_CYC);
    localparam logic [TW-1:0]     T_LAST = TW'(TRAVEL_CYC - 1);
    localparam logic [DW-1:0]     D_LAST = DW'(DOOR_CYC - 1);
    localparam logic [FLOORS-1:0] ONE    = FLOORS'(1);

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    state_t          state, state_d;
    dir_t            dir, dir_d;
    logic [FW-1:0]   pfloor_d, arrive;
    logic [TW-1:0]   tcnt, tcnt_d;
    logic [DW-1:0]   dcnt, dcnt_d;
    logic [FLOORS-1:0] clr;
    logic            above, below;

    // True when any call lies strictly beyond floor f in direction d.
    function automatic logic calls_beyond(input logic [FLOORS-1:0] p,
                                          input logic [FW-1:0] f, input dir_t d);
        logic any;
        any = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if ((d == UP && i > int'(f)) || (d == DOWN && i < int'(f)))
                any = any | p[i];
        end
        return any;
    endfunction

    assign above = calls_beyond(pending, pfloor, UP);
    assign below = calls_beyond(pending, pfloor, DOWN);

    always_comb begin
        nfloor = pfloor;
        if (state == MOVING) begin
            if (dir == UP) begin
                for (int i = FLOORS - 1; i >= 0; i--)
                    if (i > int'(pfloor) && pending[i]) nfloor = FW'(i);
            end else begin
                for (int i = 0; i < FLOORS; i++)
                    if (i < int'(pfloor) && pending[i]) nfloor = FW'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d  = state;
        dir_d    = dir;
        pfloor_d = pfloor;
        tcnt_d   = tcnt;
        dcnt_d   = dcnt;
        clr      = '0;
        arrive   = (dir == UP) ? pfloor + 1'b1 : pfloor - 1'b1;
        case (state)
            IDLE: begin
                if (pending[pfloor] || inopen) begin
                    state_d = DOOR_OPEN;
                    dcnt_d  = '0;
                    clr     = ONE << pfloor;
                end else if (above && (dir == UP || !below)) begin
                    state_d = MOVING;
                    dir_d   = UP;
                    tcnt_d  = '0;
                end else if (below) begin
                    state_d = MOVING;
                    dir_d   = DOWN;
                    tcnt_d  = '0;
                end
            end
            MOVING: begin
                if (tcnt == T_LAST) begin
                    pfloor_d = arrive;
                    tcnt_d   = '0;
                    // Stop decision uses the registered calls, judged at the new floor.
                    if (pending[arrive]) begin
                        state_d = DOOR_OPEN;
                        dcnt_d  = '0;
                        clr     = ONE << arrive;
                    end else if (!calls_beyond(pending, arrive, dir)) begin
                        state_d = IDLE;
                    end
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            DOOR_OPEN: begin
                clr = ONE << pfloor;
                if (inopen) begin
                    dcnt_d = '0;
                end else if (inclose) begin
                    state_d = IDLE;
                end else if (req[pfloor]) begin
                    dcnt_d = '0;
                end else if (dcnt == D_LAST) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            dir     <= UP;
            pending <= '0;
            pfloor  <= '0;
            tcnt    <= '0;
            dcnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            state   <= state_d;
            dir     <= dir_d;
            pending <= (pending | req) & ~clr;
            pfloor  <= pfloor_d;
            tcnt    <= tcnt_d;
            dcnt    <= dcnt_d;
        end
    end

    assign up    = (state == MOVING) && (dir == UP);
    assign down  = (state == MOVING) && (dir == DOWN);
    assign open  = (state == DOOR_OPEN);
    assign close = ~open;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: a floor/timer reference model predicts
// every cycle's outputs; a negedge monitor compares them against the design.
module tb_elevator_scheduler;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 6;
    localparam int M_IDLE = 0, M_TRAV = 1, M_DOOR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'h00;
    logic       inopen = 1'b0, inclose = 1'b0;
    logic [7:0] pending;
    logic [2:0] pfloor, nfloor;
    logic       up, down, open, close;

    always #5 clk = ~clk;

    elevator_scheduler #(.FLOORS(8), .TRAVEL_CYC(TRAVEL), .DOOR_CYC(DOOR)) dut (
        .clk(clk), .rst(rst), .req(req), .inopen(inopen), .inclose(inclose),
        .pending(pending), .pfloor(pfloor), .nfloor(nfloor),
        .up(up), .down(down), .open(open), .close(close)
    );

    typedef struct packed {
        logic [7:0] pending;
        logic [2:0] pfloor;
        logic [2:0] nfloor;
        logic       up, down, open, close;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: car position as an integer, timers count down to zero.
    int       m_pos, m_mode, m_left;
    bit       m_dn;
    bit [7:0] m_calls;

    // Nearest call strictly beyond floor f going down (dn) or up; f itself if none.
    function automatic int nearest(input bit [7:0] c, input int f, input bit dn);
        for (int d = 1; d < 8; d++) begin
            int g;
            g = dn ? f - d : f + d;
            if (g >= 0 && g <= 7 && c[g]) return g;
        end
        return f;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_mode = M_IDLE; m_left = 0; m_dn = 0; m_calls = 8'h00;
    endtask

    task automatic model_step(input bit [7:0] r, input bit io, input bit ic);
        bit [7:0] nxt;
        nxt = m_calls | r;
        case (m_mode)
            M_IDLE: begin
                if (m_calls[m_pos] || io) begin
                    m_mode = M_DOOR; m_left = DOOR; nxt[m_pos] = 1'b0;
                end else if (nearest(m_calls, m_pos, 1'b0) != m_pos &&
                             (!m_dn || nearest(m_calls, m_pos, 1'b1) == m_pos)) begin
                    m_mode = M_TRAV; m_dn = 1'b0; m_left = TRAVEL;
                end else if (nearest(m_calls, m_pos, 1'b1) != m_pos) begin
                    m_mode = M_TRAV; m_dn = 1'b1; m_left = TRAVEL;
                end
            end
            M_TRAV: begin
                m_left--;
                if (m_left == 0) begin
                    m_pos += m_dn ? -1 : 1;
                    if (m_calls[m_pos]) begin
                        m_mode = M_DOOR; m_left = DOOR; nxt[m_pos] = 1'b0;
                    end else if (nearest(m_calls, m_pos, m_dn) != m_pos) begin
                        m_left = TRAVEL;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            default: begin
                nxt[m_pos] = 1'b0;
                if (io) m_left = DOOR;
                else if (ic) m_mode = M_IDLE;
                else if (r[m_pos]) m_left = DOOR;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
        m_calls = nxt;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.pending = m_calls;
        o.pfloor  = 3'(m_pos);
        o.nfloor  = 3'((m_mode == M_TRAV) ? nearest(m_calls, m_pos, m_dn) : m_pos);
        o.up      = (m_mode == M_TRAV) && !m_dn;
        o.down    = (m_mode == M_TRAV) && m_dn;
        o.open    = (m_mode == M_DOOR);
        o.close   = (m_mode != M_DOOR);
        return o;
    endfunction

    // Predictor: one expectation per rising edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else model_step(req, inopen, inclose);
            sb.push_back(model_obs());
        end
    end

    // Monitor: compares away from the active edge; expectations are dropped during reset.
    initial begin
        obs_t e, g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                g = {pending, pfloor, nfloor, up, down, open, close};
                check("cycle_outputs", 32'(g), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int up_cnt, open_cnt;

        #3;
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_floors", 32'({pfloor, nfloor}), 32'h0);
        check("reset_cmds", 32'({up, down, open, close}), 32'b0001);
        repeat (2) tick();
        rst = 1'b1;

        // Single call to floor 3 from G.
        tick(); req = 8'h08;
        tick(); req = 8'h00;
        up_cnt = 0; open_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            up_cnt   += int'(up);
            open_cnt += int'(open);
        end
        check("trip3_up_cycles", 32'(up_cnt), 32'd12);
        check("trip3_open_cycles", 32'(open_cnt), 32'd6);
        check("trip3_floor", 32'(pfloor), 32'd3);
        check("trip3_pending", 32'(pending), 32'h0);
        check("trip3_close", 32'(close), 32'd1);

        // Call to G, then reset asynchronously while passing floor 2.
        tick(); req = 8'h01;
        tick(); req = 8'h00;
        for (int i = 0; i < 100 && !(pfloor == 3'd2 && down); i++) @(negedge clk);
        check("reach_floor2_down", 32'(pfloor == 3'd2 && down), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_pending", 32'(pending), 32'h0);
        check("async_rst_floors", 32'({pfloor, nfloor}), 32'h0);
        check("async_rst_cmds", 32'({up, down, open, close}), 32'b0001);
        tick(); tick();
        rst = 1'b1;

        // Randomized calls and door buttons against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 9) == 0) req = 8'(1 << $urandom_range(0, 7));
            else if ($urandom_range(0, 49) == 0) req = 8'($urandom);
            else req = 8'h00;
            inopen  = ($urandom_range(0, 24) == 0);
            inclose = ($urandom_range(0, 19) == 0);
        end
        req = 8'h00; inopen = 1'b0; inclose = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
